// File: rtl/dump_pkg.sv
// Shared definitions for the register-file UART dump: state encoding,
// frame geometry and baud-divider arithmetic.
package dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } state_e;

    localparam int unsigned DATA_BITS  = 32'd8;
    localparam int unsigned FRAME_BITS = 32'd10;

    function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / baud;
    endfunction

    // Counter width that stays at least one bit even for a single-entry range.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter. A load on the last stop-bit cycle chains the next
// frame with no idle gap.
module uart_tx_byte
    import dump_pkg::*;
#(
    parameter int unsigned DIV = 32'd434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int unsigned CW = cnt_width(DIV);

    state_e          state_r;
    logic [CW-1:0]   baud_cnt_r;
    logic [2:0]      bit_cnt_r;
    logic [7:0]      shift_r;
    logic            tx_r;
    logic            bit_end_s;

    assign bit_end_s = (baud_cnt_r == CW'(DIV - 32'd1));
    assign tx        = tx_r;

    // Ready while idle or in the final cycle of the stop bit.
    always_comb begin
        ready = 1'b0;
        case (state_r)
            ST_IDLE: ready = 1'b1;
            ST_STOP: ready = bit_end_s;
            default: ready = 1'b0;
        endcase
    end

    // Frame sequencer with baud and bit counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'd0;
            tx_r       <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load) begin
                        state_r    <= ST_START;
                        baud_cnt_r <= '0;
                        shift_r    <= data;
                        tx_r       <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_r    <= ST_DATA;
                        baud_cnt_r <= '0;
                        bit_cnt_r  <= 3'd0;
                        tx_r       <= shift_r[0];
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CW'(32'd1);
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= '0;
                        if (bit_cnt_r == 3'(DATA_BITS - 32'd1)) begin
                            state_r   <= ST_STOP;
                            bit_cnt_r <= 3'd0;
                            tx_r      <= 1'b1;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CW'(32'd1);
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= '0;
                        if (load) begin
                            state_r <= ST_START;
                            shift_r <= data;
                            tx_r    <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CW'(32'd1);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    baud_cnt_r <= '0;
                    bit_cnt_r  <= 3'd0;
                    tx_r       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/regfile_dump_tx.sv
// Walks the register file from address 0 upward and streams every word
// MSB byte first through uart_tx_byte; pulses done after the last stop bit.
module regfile_dump_tx
    import dump_pkg::*;
#(
    parameter  int unsigned clk_freq = 32'd50000000,
    parameter  int unsigned baud     = 32'd115200,
    parameter  int unsigned NREG     = 32'd16,
    parameter  int unsigned WIDTH    = 32'd32,
    localparam int unsigned AW       = cnt_width(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [AW-1:0]    reg_addr,
    input  logic [WIDTH-1:0] reg_rdata,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DIV    = calc_div(clk_freq, baud);
    localparam int unsigned NBYTES = WIDTH / DATA_BITS;
    localparam int unsigned BW     = cnt_width(NBYTES);

    // ST_START here covers the whole run of byte frames for one word; the
    // START/DATA/STOP detail lives inside uart_tx_byte.
    state_e           state_r;
    logic [AW-1:0]    addr_r;
    logic [BW-1:0]    byte_idx_r;
    logic [WIDTH-1:0] word_r;
    logic             busy_r;
    logic             done_r;
    logic             load_s;
    logic [7:0]       byte_s;
    logic             ready_s;

    assign reg_addr = addr_r;
    assign busy     = busy_r;
    assign done     = done_r;

    // First byte comes straight from the read port; later bytes from the latched word.
    always_comb begin
        load_s = 1'b0;
        byte_s = word_r[WIDTH-1 -: 8];
        case (state_r)
            ST_LOAD: begin
                load_s = 1'b1;
                byte_s = reg_rdata[WIDTH-1 -: 8];
            end
            ST_START: begin
                if (ready_s && (byte_idx_r != '0)) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            default: load_s = 1'b0;
        endcase
    end

    // Register/byte sequencing; start is not accepted in the done cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            addr_r     <= '0;
            byte_idx_r <= '0;
            word_r     <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && !done_r) begin
                        state_r <= ST_ADDR;
                        addr_r  <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    state_r <= ST_LOAD;
                end
                ST_LOAD: begin
                    word_r     <= reg_rdata << DATA_BITS;
                    byte_idx_r <= BW'(NBYTES - 32'd1);
                    state_r    <= ST_START;
                end
                ST_START: begin
                    if (ready_s) begin
                        if (byte_idx_r != '0) begin
                            byte_idx_r <= byte_idx_r - BW'(32'd1);
                            word_r     <= word_r << DATA_BITS;
                        end else if (addr_r < AW'(NREG - 32'd1)) begin
                            addr_r  <= addr_r + AW'(32'd1);
                            state_r <= ST_ADDR;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .DIV (DIV)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .load  (load_s),
        .data  (byte_s),
        .tx    (tx),
        .ready (ready_s)
    );

endmodule
